// File: rtl/ifft_stream_out.sv
// Converts a wide complex IFFT sample stream into rounded, saturated words
// with frame tagging and a small FIFO feeding a valid/ready output port.
module ifft_stream_out #(
   parameter int IW     = 21,
   parameter int OW     = 16,
   parameter int SHIFT  = 5,
   parameter int LGSIZE = 11,
   parameter int LGFIFO = 4
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_ce,
   input  logic              i_sync,
   input  logic [2*IW-1:0]   i_sample,
   output logic              o_valid,
   input  logic              i_ready,
   output logic [2*OW-1:0]   o_data,
   output logic              o_last,
   output logic              o_overflow,
   output logic [1:0]        o_state
);

   localparam int DEPTH = 1 << LGFIFO;
   localparam logic signed [IW:0]  MAX_V = (IW+1)'(2**(OW-1) - 1);
   localparam logic signed [IW:0]  MIN_V = (IW+1)'(-(2**(OW-1)));
   localparam logic [SHIFT-1:0]    HALF  = SHIFT'(2**(SHIFT-1));
   localparam logic [LGSIZE-1:0]   LAST_IDX = '1;
   localparam logic [LGFIFO:0]     FULL_CNT = (LGFIFO+1)'(DEPTH);

   typedef enum logic [1:0] {
      HUNT = 2'd0,
      RUN  = 2'd1,
      DROP = 2'd2
   } state_t;

   // Round-half-to-even on the discarded bits, then clip to OW bits.
   function automatic logic [OW-1:0] round_sat(input logic [IW-1:0] x);
      logic signed [IW:0] xe;
      logic signed [IW:0] t;
      logic signed [IW:0] r;
      logic signed [IW:0] sat;
      logic [SHIFT-1:0]   d;
      logic               up;
      xe  = {x[IW-1], x};
      t   = xe >>> SHIFT;
      d   = x[SHIFT-1:0];
      up  = (d > HALF) || ((d == HALF) && t[0]);
      r   = t + (IW+1)'(up);
      if (r > MAX_V)
         sat = MAX_V;
      else if (r < MIN_V)
         sat = MIN_V;
      else
         sat = r;
      return OW'(sat);
   endfunction

   state_t              state, state_nx;
   logic [LGSIZE-1:0]   frame_cnt, frame_cnt_nx;
   logic [LGSIZE-1:0]   idx;
   logic                keep;

   logic                p_valid;
   logic                p_last;
   logic [2*OW-1:0]     p_data;

   logic [2*OW:0]       mem [DEPTH];
   logic [LGFIFO-1:0]   wr_ptr, rd_ptr;
   logic [LGFIFO:0]     count;
   logic                full, wr_en, rd_en, ovf_evt;
   logic [2*OW:0]       head;

   // Output port: a word transfers on a rising edge where o_valid && i_ready;
   // once o_valid is high, o_valid/o_data/o_last hold until that transfer.
   assign head    = mem[rd_ptr];
   assign o_valid = (count != '0);
   assign o_data  = head[2*OW-1:0];
   assign o_last  = o_valid && head[2*OW];
   assign o_state = state;

   assign full    = (count == FULL_CNT);
   assign rd_en   = o_valid && i_ready;
   assign wr_en   = p_valid && (!full || rd_en);
   assign ovf_evt = p_valid && full && !rd_en;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state     <= HUNT;
         frame_cnt <= '0;
      end else begin
         state     <= state_nx;
         frame_cnt <= frame_cnt_nx;
      end
   end

   always_comb begin
      state_nx     = state;
      frame_cnt_nx = frame_cnt;
      keep         = 1'b0;
      idx          = frame_cnt;
      case (state)
         HUNT, DROP: begin
            if (i_ce && i_sync) begin
               keep         = 1'b1;
               idx          = '0;
               frame_cnt_nx = LGSIZE'(1);
               state_nx     = RUN;
            end
         end
         RUN: begin
            if (i_ce) begin
               keep         = 1'b1;
               idx          = i_sync ? '0 : frame_cnt;
               frame_cnt_nx = idx + LGSIZE'(1);
            end
            if (ovf_evt)
               state_nx = DROP;
         end
         default: state_nx = HUNT;
      endcase
   end

   // Rounding stage: loads on i_ce, hands the word to the FIFO next cycle.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         p_valid <= 1'b0;
      end else begin
         p_valid <= keep;
      end
      if (i_ce) begin
         p_data <= {round_sat(i_sample[2*IW-1:IW]), round_sat(i_sample[IW-1:0])};
         p_last <= keep && (idx == LAST_IDX);
      end
   end

   always_ff @(posedge i_clk) begin
      if (wr_en)
         mem[wr_ptr] <= {p_last, p_data};
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         o_overflow <= 1'b0;
      end else begin
         if (wr_en)
            wr_ptr <= wr_ptr + LGFIFO'(1);
         if (rd_en)
            rd_ptr <= rd_ptr + LGFIFO'(1);
         case ({wr_en, rd_en})
            2'b10:   count <= count + (LGFIFO+1)'(1);
            2'b01:   count <= count - (LGFIFO+1)'(1);
            default: count <= count;
         endcase
         if (ovf_evt)
            o_overflow <= 1'b1;
      end
   end

endmodule

// File: doc/ifft_stream_out.md
IFFT_STREAM_OUT -- requirements
Module: ifft_stream_out

Interface
- REQ-001 Parameters SHALL be:
  - IW, default 21: input component width.
  - OW, default 16: output component width.
  - SHIFT, default 5: right-shift applied before rounding.
  - LGSIZE, default 11: log2 frame length.
  - LGFIFO, default 4: log2 FIFO depth.
- REQ-002 i_clk  in  1  clock; all logic rising-edge.
- REQ-003 i_reset  in  1  reset, synchronous, active-high.
- REQ-004 i_ce  in  1  input sample strobe; one sample per asserted cycle.
- REQ-005 i_sync  in  1  qualified by i_ce; marks the first sample of a frame.
- REQ-006 i_sample  in  2*IW  real in high half, imaginary in low half, two's complement.
- REQ-007 o_valid  out  1  output word available.
- REQ-008 i_ready  in  1  downstream accepts word when o_valid && i_ready.
- REQ-009 o_data  out  2*OW  real high, imaginary low.
- REQ-010 o_last  out  1  qualifies o_data; last sample of a frame.
- REQ-011 o_overflow  out  1  sticky; sample dropped since reset.

Function
- REQ-012 Rounding SHALL be per component: arithmetic right shift by SHIFT with convergent rounding (round-half-to-even) on the discarded bits, then saturation to OW bits.
  - Positive clip value: 2^(OW-1)-1.
  - Negative clip value: -2^(OW-1).
- REQ-013 Rounding SHALL be registered: one pipeline stage, advancing only on i_ce; its sync/last flags travel with it.
- REQ-014 The FSM SHALL have three states: HUNT, RUN, DROP.
  - Reset state is HUNT.
- REQ-015 HUNT: samples are discarded. A sample with i_ce && i_sync is kept as index 0 and the FSM enters RUN.
- REQ-016 RUN: every i_ce sample is kept. The LGSIZE-bit frame counter increments and wraps 2^LGSIZE-1 -> 0.
  - Index 2^LGSIZE-1 is tagged last.
  - i_sync at a nonzero index forces the index to 0 (resync). It does not raise an error.
- REQ-017 The FIFO SHALL be 2^LGFIFO entries × (2*OW+1) bits (data plus last tag). It is written when a rounded sample leaves the pipeline stage.
- REQ-018 Full/empty rules:
  - A write when full with no simultaneous read SHALL drop the sample, set o_overflow, and move the FSM to DROP.
  - A write and a read in the same cycle at full SHALL both succeed.
  - A read when empty SHALL never occur; o_valid=0 when empty.
- REQ-019 DROP: all samples are discarded and the FIFO drains normally. An i_ce && i_sync sample returns the FSM to RUN at index 0.
  - Words already queued, including a partial frame without o_last, SHALL still be delivered.
- REQ-020 Output handshake:
  - o_data and o_last SHALL hold stable while o_valid && !i_ready.
  - o_valid SHALL not drop without a handshake.
- REQ-021 Latency: a kept sample accepted at cycle n with the FIFO empty SHALL appear with o_valid at cycle n+2.
  - Throughput: one word per cycle while i_ready is held high.
- REQ-022 The FIFO occupancy counter SHALL span 0..2^LGFIFO inclusive.

Reset
- REQ-023 On i_reset the block SHALL:
  - clear o_valid, o_last, o_overflow and the FIFO pointers/count;
  - clear the frame counter and the pipeline valid flag;
  - set the FSM to HUNT.
- REQ-024 o_data SHALL be don't-care while o_valid=0.
- REQ-025 Reset mid-frame or mid-DROP SHALL discard all queued words; nothing stale SHALL emerge after reset.

Verification
- REQ-026 Reset, then 5 i_ce samples without i_sync, then i_sync with 2^LGSIZE samples, i_ready=1 -> exactly 2048 words out; o_last only on word 2047; first word equals rounded sync sample.
- REQ-027 Rounding, component values with SHIFT=5:
  - 48 (1.5 LSB) -> 2.
  - 80 (2.5) -> 2.
  - -48 -> -2.
  - 2^20-1 -> saturates to 32767.
  - -2^20 -> -32768.
- REQ-028 i_ready=0 with continuous i_ce after sync -> 16 words buffered, 17th sample sets o_overflow, FSM in DROP. Then i_ready=1 -> exactly 16 words with no o_last. Next i_sync -> clean 2048-word frame; o_overflow stays 1.
- REQ-029 FIFO full plus i_ready=1 and i_ce=1 in the same cycle -> no overflow; word count preserved.
- REQ-030 i_ce every third cycle, random i_ready -> output sequence equals the input sequence; no loss, no duplication.
- REQ-031 Assert i_reset at frame index 1000 with 10 words queued -> o_valid=0 the next cycle; output resumes only after a new i_sync.
